// File: rtl/display_scan_controller_if.sv
// Character-bank / display-drive bundle between the score logic and the scanner.
// The master side produces character codes and controls; the slave side is the scanner.
interface display_scan_controller_if #(
    parameter int NUM_DIGITS = 7,
    parameter int CHAR_W     = 7
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS*CHAR_W-1:0] chars;
    logic                         load;
    logic [NUM_DIGITS-1:0]        digit_en;
    logic [NUM_DIGITS-1:0]        blink_mask;
    logic [CHAR_W-1:0]            one_char;
    logic [NUM_DIGITS-1:0]        anode;
    logic [IDX_W-1:0]             digit_idx;
    logic                         frame_done;

    modport master (
        output chars, load, digit_en, blink_mask,
        input  one_char, anode, digit_idx, frame_done
    );

    modport slave (
        input  chars, load, digit_en, blink_mask,
        output one_char, anode, digit_idx, frame_done
    );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexed seven-segment scanner: self-timed digit slots with dead-time,
// frame-synchronous double-buffered character bank, per-digit enable and blink.
module display_scan_controller #(
    parameter int               NUM_DIGITS       = 7,
    parameter int               CHAR_W           = 7,
    parameter int               PRESCALE         = 100000,
    parameter int               DEAD_CYCLES      = 4,
    parameter int               BLINK_FRAMES     = 64,
    parameter logic [CHAR_W-1:0] BLANK_CODE      = 7'h7F,
    parameter bit               ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    display_scan_controller_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(PRESCALE);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int BUF_W = NUM_DIGITS * CHAR_W;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [BUF_W-1:0] BLANK_BANK = {NUM_DIGITS{BLANK_CODE}};

    typedef enum logic {DEAD, DRIVE} state_t;

    state_t                 state_reg, state_next;
    logic [PRE_W-1:0]       prescaler_reg, prescaler_next;
    logic [PRE_W-1:0]       dead_cnt_reg, dead_cnt_next;
    logic [IDX_W-1:0]       digit_idx_reg, digit_idx_next;
    logic [BUF_W-1:0]       active_reg, active_next;
    logic [BUF_W-1:0]       shadow_reg, shadow_next;
    logic                   pending_reg, pending_next;
    logic [FRM_W-1:0]       frame_cnt_reg, frame_cnt_next;
    logic                   blink_phase_reg, blink_phase_next;
    logic [CHAR_W-1:0]      one_char_reg, one_char_next;
    logic [NUM_DIGITS-1:0]  anode_reg, anode_next;
    logic                   frame_done_reg;

    logic                   tick;
    logic                   wrap;
    logic                   visible;
    logic [NUM_DIGITS-1:0]  drive_sel;
    logic [CHAR_W-1:0]      active_char [NUM_DIGITS];

    assign tick = (prescaler_reg == PRE_W'(PRESCALE - 1));
    assign wrap = tick && (digit_idx_reg == IDX_W'(NUM_DIGITS - 1));

    // Timing, slot sequencing and the frame-synchronous buffer swap.
    always_comb begin
        prescaler_next   = tick ? '0 : prescaler_reg + 1'b1;
        state_next       = state_reg;
        dead_cnt_next    = dead_cnt_reg;
        digit_idx_next   = digit_idx_reg;
        active_next      = active_reg;
        shadow_next      = shadow_reg;
        pending_next     = pending_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;

        if (tick) begin
            digit_idx_next = wrap ? '0 : digit_idx_reg + 1'b1;
            dead_cnt_next  = '0;
            state_next     = (DEAD_CYCLES == 0) ? DRIVE : DEAD;
        end else if (state_reg == DEAD) begin
            dead_cnt_next = dead_cnt_reg + 1'b1;
            if (DEAD_CYCLES == 0 || dead_cnt_reg == PRE_W'(DEAD_CYCLES - 1))
                state_next = DRIVE;
        end

        // A load coinciding with the frame wrap bypasses the shadow stage.
        if (bus.load && wrap) begin
            active_next  = bus.chars;
            shadow_next  = bus.chars;
            pending_next = 1'b0;
        end else if (bus.load) begin
            shadow_next  = bus.chars;
            pending_next = 1'b1;
        end else if (wrap && pending_reg) begin
            active_next  = shadow_reg;
            pending_next = 1'b0;
        end

        if (wrap) begin
            if (frame_cnt_reg == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign active_char[gi] = active_next[gi*CHAR_W +: CHAR_W];
        assign drive_sel[gi]   = (digit_idx_next == IDX_W'(gi));
    end

    // Outputs are registered from the next-cycle view so they line up with the slot state.
    always_comb begin
        visible = (state_next == DRIVE) && bus.digit_en[digit_idx_next] &&
                  !(bus.blink_mask[digit_idx_next] && blink_phase_next);
        anode_next    = ANODE_OFF;
        one_char_next = BLANK_CODE;
        if (visible) begin
            anode_next    = ANODE_ACTIVE_LOW ? ~drive_sel : drive_sel;
            one_char_next = active_char[digit_idx_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= DEAD;
            prescaler_reg   <= '0;
            dead_cnt_reg    <= '0;
            digit_idx_reg   <= '0;
            active_reg      <= BLANK_BANK;
            shadow_reg      <= BLANK_BANK;
            pending_reg     <= 1'b0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            one_char_reg    <= BLANK_CODE;
            anode_reg       <= ANODE_OFF;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            prescaler_reg   <= prescaler_next;
            dead_cnt_reg    <= dead_cnt_next;
            digit_idx_reg   <= digit_idx_next;
            active_reg      <= active_next;
            shadow_reg      <= shadow_next;
            pending_reg     <= pending_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
            one_char_reg    <= one_char_next;
            anode_reg       <= anode_next;
            frame_done_reg  <= wrap;
        end
    end

    assign bus.one_char   = one_char_reg;
    assign bus.anode      = anode_reg;
    assign bus.digit_idx  = digit_idx_reg;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Parametrised multiplexed-display scanner for the seven-segment character path. It generates its own refresh timing and double-buffers the character bank so updates never tear mid-frame. Per digit it drives one character code plus the matching anode, with dead-time between digits, per-digit enable and per-digit blink. It sits between the game/score logic that produces character codes and the segment decoder/anode pins.

Parameters:
NUM_DIGITS, 7, number of multiplexed digits (>=2).
CHAR_W, 7, width of one character code.
PRESCALE, 100000, clocks per digit slot (>=DEAD_CYCLES+2).
DEAD_CYCLES, 4, clocks per slot with all anodes off (0 = none).
BLINK_FRAMES, 64, frames per blink half-period (>=1).
BLANK_CODE, 7'h7F, char code driven when blank (width CHAR_W).
ANODE_ACTIVE_LOW, 1, 1 = anode asserted low.

Ports:
clk  in  1  system clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
chars  in  NUM_DIGITS*CHAR_W  character bank; digit k at [k*CHAR_W +: CHAR_W]; digit 0 = rightmost.
load  in  1  one-cycle strobe, samples chars into shadow buffer.
digit_en  in  NUM_DIGITS  1 = digit displayed; 0 = forced blank.
blink_mask  in  NUM_DIGITS  1 = digit blinks.
one_char  out  CHAR_W  registered code for current digit.
anode  out  NUM_DIGITS  registered one-hot (or all-off) anode drive.
digit_idx  out  $clog2(NUM_DIGITS)  registered current slot index.
frame_done  out  1  one-cycle pulse on wrap NUM_DIGITS-1 -> 0.

Behaviour:
- Reset (async, any time): prescaler=0, digit_idx=0, state=DEAD, dead_cnt=0, active and shadow buffers all BLANK_CODE, pending=0, frame_cnt=0, blink_phase=0, one_char=BLANK_CODE, anode=all inactive, frame_done=0. Any in-flight load is discarded.
- Prescaler free-runs 0..PRESCALE-1 and wraps; tick = (prescaler==PRESCALE-1).
- On tick edge: digit_idx advances (NUM_DIGITS-1 wraps to 0), state->DEAD, dead_cnt=0, anode all inactive, one_char=BLANK_CODE. If DEAD_CYCLES=0, go straight to DRIVE using the new index.
- DEAD: dead_cnt increments each clock. On the edge where dead_cnt==DEAD_CYCLES-1, state->DRIVE.
- DRIVE: anode[digit_idx] active, others inactive, one_char=active[digit_idx]. The slot is visible when digit_en[i]=1 and NOT (blink_mask[i] & blink_phase).
- A non-visible slot drives all anodes inactive and one_char=BLANK_CODE.
- digit_en and blink_mask are sampled continuously, with one-cycle output latency.
- Each slot gives PRESCALE-DEAD_CYCLES clocks of drive.
- frame_done is registered high for exactly the cycle after the wrapping tick edge.
- frame_cnt increments on each wrap. At frame_cnt==BLINK_FRAMES-1 it clears and blink_phase toggles.
- Double buffer:
  - load edge: shadow<=chars, pending=1.
  - Wrapping tick with pending=1: active<=shadow, pending=0.
  - load on the same edge as a wrapping tick: active<=chars and shadow<=chars directly, pending=0.
  - Repeated loads before a wrap: last one wins.
- Active buffer changes only at frame boundaries, never mid-frame.
- Disabled digit: its buffer content is retained, only the output is blanked.

Test Plan:
Parameters for all scenarios: NUM_DIGITS=4, CHAR_W=7, PRESCALE=8, DEAD_CYCLES=2, BLINK_FRAMES=2, ANODE_ACTIVE_LOW=1, BLANK_CODE=7'h7F, digit_en=4'hF, blink_mask=0.
1. Release reset, no load:
   - Cycles 0-1: anode=4'hF.
   - Cycles 2-7: anode=4'hE, one_char=7'h7F.
   - Edge after cycle 31: frame_done pulses and digit_idx returns to 0.
2. Pulse load with chars={7'h03,7'h02,7'h01,7'h00} mid-frame 0:
   - Frame 0 still shows 7'h7F.
   - Frame 1 drives 7'h00,7'h01,7'h02,7'h03 with anodes E,D,B,7.
3. Pulse load exactly on the wrapping tick edge: new codes visible in digit 0 of the immediately following frame, pending=0.
4. Set digit_en=4'b1011: slot 2 shows anode=4'hF and one_char=7'h7F for the full slot; slots 0, 1 and 3 are unaffected.
5. Set blink_mask=4'b0001:
   - Digit 0 visible in frames 0-1, blank in frames 2-3, visible in frames 4-5.
   - Other digits stay steady.
6. Assert rst_n low mid-DRIVE of slot 2 with pending=1:
   - All outputs return to reset values asynchronously.
   - After release: buffers blank, no stale load applied.
